// File: rtl/routing_pkg.sv
// routing_pkg: shared FSM states and table-format constants for the routing stages
package routing_pkg;
  typedef enum logic [2:0] {IDLE, CNT, ID, COST, DONE} state_t;
  localparam logic [15:0] INVALID_ID = 16'hFFFF;
  localparam logic [15:0] INVALID_COST = 16'hFFFF;
  localparam logic [15:0] ENTRY_STRIDE = 16'd4;
  localparam logic [15:0] HDR_BYTES = 16'd2;
endpackage

// File: rtl/next_hop_select.sv
// next_hop_select: scans the neighbour table and picks the cheapest valid neighbour as next hop
module next_hop_select
  import routing_pkg::*;
#(
  parameter logic [15:0] TABLE_BASE = 16'd64,
  parameter int MAX_NEIGHBORS = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        iamSink,
  input  logic [15:0] MY_NODE_ID,
  output logic [15:0] address,
  input  logic [15:0] mem_data_out,
  output logic        busy,
  output logic [15:0] next_hop,
  output logic [15:0] best_cost,
  output logic        found,
  output logic        done
);
  localparam int CW = $clog2(MAX_NEIGHBORS + 1);
  localparam logic [15:0] MAXW = 16'(MAX_NEIGHBORS);
  state_t state, state_n;
  logic [CW-1:0] count, count_n, idx, idx_nx;
  logic [15:0] cand_id;
  logic accept;
  function automatic logic [15:0] entry_addr(input logic [CW-1:0] i);
    return TABLE_BASE + HDR_BYTES + ENTRY_STRIDE * 16'(i);
  endfunction
  assign count_n = (mem_data_out > MAXW) ? CW'(MAX_NEIGHBORS) : mem_data_out[CW-1:0];
  assign idx_nx = idx + CW'(1);
  assign accept = cand_id != MY_NODE_ID && cand_id != INVALID_ID &&
                  mem_data_out != INVALID_COST && mem_data_out < best_cost;
  assign busy = state == CNT || state == ID || state == COST;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    address = TABLE_BASE;
    unique case (state)
      IDLE: state_n = start ? (iamSink ? DONE : CNT) : IDLE;
      CNT: begin
        address = entry_addr('0);
        state_n = (count_n == '0) ? DONE : ID;
      end
      ID: begin
        address = entry_addr(idx) + 16'd2;
        state_n = COST;
      end
      COST: begin
        address = entry_addr(idx_nx);
        state_n = (idx_nx == count) ? DONE : ID;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      next_hop <= INVALID_ID;
      best_cost <= INVALID_COST;
      found <= 1'b0;
      idx <= '0;
      count <= '0;
      cand_id <= INVALID_ID;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        next_hop <= iamSink ? MY_NODE_ID : INVALID_ID;
        best_cost <= iamSink ? 16'd0 : INVALID_COST;
        found <= iamSink;
        idx <= '0;
      end
      if (state == CNT) count <= count_n;
      if (state == ID) cand_id <= mem_data_out;
      if (state == COST) begin
        idx <= idx_nx;
        if (accept) begin
          next_hop <= cand_id;
          best_cost <= mem_data_out;
          found <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/next_hop_select.md
# next_hop_select

Downstream stage of the sink-election block. It starts on that block's done pulse. If the node is the sink, it reports itself as the route end. Otherwise it scans the neighbour table in the shared data memory and selects the valid neighbour with the lowest cost as next hop. Results are held stable for the packet-forwarding logic until the next start.

## Interface
- TABLE_BASE, 16'd64, byte address of the neighbour-table header word.
- MAX_NEIGHBORS, 64, upper clamp on the scanned entry count.
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle pulse; wired to the sink-election done output.
- iamSink  input  1  sink-election result, sampled with start.
- MY_NODE_ID  input  16  this node's ID.
- address  output  16  memory byte address, combinational from state and index.
- mem_data_out  input  16  memory read word, valid one cycle after address.
- busy  output  1  high while scanning; top level grants the memory read port on busy.
- next_hop  output  16  selected neighbour ID (16'hFFFF if none).
- best_cost  output  16  cost of the selected neighbour (16'hFFFF if none).
- found  output  1  a valid next hop exists.
- done  output  1  one-cycle pulse when results are final.

## Operation
- Table layout (16-bit words, 2 bytes each):
  - header word N at TABLE_BASE;
  - entry i: ID at TABLE_BASE+2+4i, cost at TABLE_BASE+4+4i.
  - Address arithmetic is 16-bit and wraps modulo 2^16.
- States:
  - IDLE: address=TABLE_BASE.
    - start&iamSink → DONE, loading next_hop=MY_NODE_ID, best_cost=0, found=1.
    - start&!iamSink → CNT, clearing best_cost=16'hFFFF, next_hop=16'hFFFF, found=0, index=0.
  - CNT: address=entry 0 ID.
    - Latch count=min(N, MAX_NEIGHBORS).
    - count==0 → DONE, else → ID.
  - ID: address=entry index cost. Latch cand_id → COST.
  - COST: address=entry index+1 ID.
    - Candidate accepted iff cand_id≠MY_NODE_ID, cand_id≠16'hFFFF, cost≠16'hFFFF and cost<best_cost.
    - Comparison is strict unsigned, so ties keep the lowest index.
    - Accept → update next_hop, best_cost, found=1.
    - index+1==count → DONE, else index++ → ID.
  - DONE: done=1 for one cycle → IDLE.
- busy=1 in CNT, ID, COST.
- start is ignored outside IDLE; iamSink is ignored except when start is sampled.

## Timing
- Reset values: state IDLE, done=0, busy=0, found=0, next_hop=16'hFFFF, best_cost=16'hFFFF, index=0.
- Memory read latency is 1 cycle: the word for an address driven during cycle t is on mem_data_out during cycle t+1.
- Latency, with start sampled at edge E:
  - sink path: done high in the cycle after E;
  - scan path: done high in the cycle after edge E+1+2·count.
- Outputs next_hop/best_cost/found:
  - are final when done rises;
  - remain unchanged until the next accepted start;
  - change only in COST or on start.
- Reset mid-scan: returns to IDLE at that edge with reset values; no done pulse.
- start coincident with reset: reset wins.
- N>MAX_NEIGHBORS: only the first MAX_NEIGHBORS entries are read.

## Structure
- Shared package routing_pkg: state enum, INVALID_ID=16'hFFFF, INVALID_COST=16'hFFFF, ENTRY_STRIDE=4, HDR_BYTES=2.
- Single module; no sub-module is natural (the comparator and address generator are a few lines each).
- The memory address mux between sink election and this block lives in the top level, selected by busy.

## Test plan
- Sink path: iamSink=1, MY_NODE_ID=17, start → done in the next cycle; next_hop=17, best_cost=0, found=1, no memory reads.
- Normal scan: table {N=3: (5,40),(9,12),(3,30)}, MY_NODE_ID=17 → done at E+7; next_hop=9, best_cost=12, found=1.
- Ties and filtering: {N=4: (17,1),(6,20),(8,20),(11,16'hFFFF)} → next_hop=6, best_cost=20 (self and invalid-cost entries skipped, tie keeps lower index).
- Empty and clamp:
  - N=0 → done at E+1, found=0, next_hop=16'hFFFF;
  - N=100 with MAX_NEIGHBORS=4 → exactly 4 entries read, done at E+9.
- Reset mid-scan: N=3, reset asserted during the second ID state → next edge returns to IDLE with reset values and no done; a fresh start then completes normally.
- start during busy: a second start pulse while busy=1 → ignored, single done pulse, results unaffected.
